// File: rtl/gpio_port_pcint.sv
// rtl/gpio_port_pcint.sv - GPIO port with DDR/PORT/PIN registers, pad synchroniser and pin-change interrupt
module gpio_port_pcint #(
    parameter int WIDTH       = 8,
    parameter int DDR_DEFAULT = 0,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ddr_we,
    input  logic [WIDTH-1:0] ddr_wdata,
    input  logic             port_we,
    input  logic [WIDTH-1:0] port_wdata,
    input  logic             pin_we,
    input  logic [WIDTH-1:0] pin_wdata,
    input  logic             pcmsk_we,
    input  logic [WIDTH-1:0] pcmsk_wdata,
    input  logic             pcif_clr,
    input  logic [WIDTH-1:0] pad_in,
    output logic [WIDTH-1:0] ddr_out,
    output logic [WIDTH-1:0] port_out,
    output logic [WIDTH-1:0] pin_out,
    output logic [WIDTH-1:0] pcmsk_out,
    output logic [WIDTH-1:0] pad_oe,
    output logic [WIDTH-1:0] pad_do,
    output logic [WIDTH-1:0] pad_pu,
    output logic             pcif,
    output logic             irq
);

    localparam int              CW      = $clog2(SYNC_STAGES + 2);
    localparam logic [CW-1:0]   ARM_MAX = CW'(SYNC_STAGES + 1);
    localparam logic [WIDTH-1:0] RST_VAL = (DDR_DEFAULT != 0) ? '1 : '0;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_pin;
    logic [WIDTH-1:0] change;
    logic [CW-1:0]    arm_cnt;
    logic             armed;
    logic             hit;

    always_comb begin
        change = '0;
        if (EDGE_MODE == 1)
            change = pin_out & ~prev_pin;
        else if (EDGE_MODE == 2)
            change = ~pin_out & prev_pin;
        else
            change = pin_out ^ prev_pin;
    end

    // Arming masks the synchroniser filling up with a static high pad after reset.
    assign armed = (arm_cnt == ARM_MAX);
    assign hit   = (|(change & pcmsk_out)) & armed;

    always_ff @(posedge clk) begin
        if (clr) begin
            ddr_out   <= RST_VAL;
            port_out  <= RST_VAL;
            pcmsk_out <= '0;
            pcif      <= 1'b0;
            prev_pin  <= '0;
            arm_cnt   <= '0;
            for (int i = 0; i < SYNC_STAGES; i++)
                sync_q[i] <= '0;
        end else begin
            if (ddr_we)
                ddr_out <= ddr_wdata;
            if (pcmsk_we)
                pcmsk_out <= pcmsk_wdata;
            if (port_we)
                port_out <= port_wdata;
            else if (pin_we)
                port_out <= port_out ^ pin_wdata;
            sync_q[0] <= pad_in;
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
            prev_pin <= pin_out;
            if (!armed)
                arm_cnt <= arm_cnt + 1'b1;
            pcif <= hit | (pcif & ~pcif_clr);
        end
    end

    assign pin_out = sync_q[SYNC_STAGES-1];
    assign pad_oe  = ddr_out;
    assign pad_do  = port_out & ddr_out;
    assign pad_pu  = port_out & ~ddr_out;
    assign irq     = pcif;

endmodule

// File: tb/tb_gpio_port_pcint.sv
// tb/tb_gpio_port_pcint.sv - self-checking bench for gpio_port_pcint (any-edge and falling-edge builds)
module tb_gpio_port_pcint;

    logic       clk = 1'b0;
    logic       clr, ddr_we, port_we, pin_we, pcmsk_we, pcif_clr;
    logic [7:0] ddr_wdata, port_wdata, pin_wdata, pcmsk_wdata, pad_in;

    logic [7:0] ddr_o [2], port_o [2], pin_o [2], pcmsk_o [2], oe_o [2], do_o [2], pu_o [2];
    logic       pcif_o [2], irq_o [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gpio_port_pcint #(.WIDTH(8), .DDR_DEFAULT(0), .SYNC_STAGES(2), .EDGE_MODE(0)) dut0 (
        .clk(clk), .clr(clr), .ddr_we(ddr_we), .ddr_wdata(ddr_wdata),
        .port_we(port_we), .port_wdata(port_wdata), .pin_we(pin_we), .pin_wdata(pin_wdata),
        .pcmsk_we(pcmsk_we), .pcmsk_wdata(pcmsk_wdata), .pcif_clr(pcif_clr), .pad_in(pad_in),
        .ddr_out(ddr_o[0]), .port_out(port_o[0]), .pin_out(pin_o[0]), .pcmsk_out(pcmsk_o[0]),
        .pad_oe(oe_o[0]), .pad_do(do_o[0]), .pad_pu(pu_o[0]), .pcif(pcif_o[0]), .irq(irq_o[0]));

    gpio_port_pcint #(.WIDTH(8), .DDR_DEFAULT(0), .SYNC_STAGES(3), .EDGE_MODE(2)) dut1 (
        .clk(clk), .clr(clr), .ddr_we(ddr_we), .ddr_wdata(ddr_wdata),
        .port_we(port_we), .port_wdata(port_wdata), .pin_we(pin_we), .pin_wdata(pin_wdata),
        .pcmsk_we(pcmsk_we), .pcmsk_wdata(pcmsk_wdata), .pcif_clr(pcif_clr), .pad_in(pad_in),
        .ddr_out(ddr_o[1]), .port_out(port_o[1]), .pin_out(pin_o[1]), .pcmsk_out(pcmsk_o[1]),
        .pad_oe(oe_o[1]), .pad_do(do_o[1]), .pad_pu(pu_o[1]), .pcif(pcif_o[1]), .irq(irq_o[1]));

    // Reference model: pin_out is the pad value sampled S edges back in a history list.
    int         m_stages [2] = '{2, 3};
    int         m_mode   [2] = '{0, 2};
    logic [7:0] m_ddr, m_port, m_pcmsk;
    logic [7:0] m_pin [2], m_prev [2];
    logic       m_pcif [2];
    logic [7:0] hist [8];
    int         edges;

    task automatic model_step();
        logic [7:0] chg;
        logic       hit;
        if (clr) begin
            m_ddr = 8'h00; m_port = 8'h00; m_pcmsk = 8'h00; edges = 0;
            for (int k = 0; k < 8; k++) hist[k] = 8'h00;
            for (int i = 0; i < 2; i++) begin
                m_pin[i] = 8'h00; m_prev[i] = 8'h00; m_pcif[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                case (m_mode[i])
                    1:       chg = m_pin[i] & ~m_prev[i];
                    2:       chg = ~m_pin[i] & m_prev[i];
                    default: chg = m_pin[i] ^ m_prev[i];
                endcase
                hit = ((chg & m_pcmsk) != 8'h00) && (edges >= m_stages[i] + 1);
                m_pcif[i] = hit || (m_pcif[i] && !pcif_clr);
            end
            for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = pad_in;
            if (edges < 1000) edges++;
            for (int i = 0; i < 2; i++) begin
                m_prev[i] = m_pin[i];
                m_pin[i]  = (edges >= m_stages[i]) ? hist[m_stages[i]-1] : 8'h00;
            end
            if (ddr_we) m_ddr = ddr_wdata;
            if (pcmsk_we) m_pcmsk = pcmsk_wdata;
            if (port_we) m_port = port_wdata;
            else if (pin_we) m_port = m_port ^ pin_wdata;
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("ddr[%0d]", i),   ddr_o[i],   m_ddr);
            check($sformatf("port[%0d]", i),  port_o[i],  m_port);
            check($sformatf("pin[%0d]", i),   pin_o[i],   m_pin[i]);
            check($sformatf("pcmsk[%0d]", i), pcmsk_o[i], m_pcmsk);
            check($sformatf("oe[%0d]", i),    oe_o[i],    m_ddr);
            check($sformatf("do[%0d]", i),    do_o[i],    m_port & m_ddr);
            check($sformatf("pu[%0d]", i),    pu_o[i],    m_port & ~m_ddr);
            check($sformatf("pcif[%0d]", i),  {7'd0, pcif_o[i]}, {7'd0, m_pcif[i]});
            check($sformatf("irq[%0d]", i),   {7'd0, irq_o[i]},  {7'd0, m_pcif[i]});
        end
    endtask

    task automatic idle_inputs();
        clr = 0; ddr_we = 0; port_we = 0; pin_we = 0; pcmsk_we = 0; pcif_clr = 0;
        ddr_wdata = 0; port_wdata = 0; pin_wdata = 0; pcmsk_wdata = 0;
    endtask

    // Inputs are already driven; advance one edge and compare everything against the model.
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic step_pad(input logic [7:0] p);
        idle_inputs();
        pad_in = p;
        step();
    endtask

    typedef struct {
        logic       clr;
        logic       dwe;  logic [7:0] dd;
        logic       pwe;  logic [7:0] pd;
        logic       nwe;  logic [7:0] nd;
        logic       mwe;  logic [7:0] md;
        logic       pc;
        logic [7:0] pad;
        logic [7:0] e_port;
        logic [7:0] e_pin;
        logic       e_pcif;
    } vec_t;

    function automatic vec_t mk(logic c, logic dwe, logic [7:0] dd, logic pwe, logic [7:0] pd,
                                logic nwe, logic [7:0] nd, logic mwe, logic [7:0] md, logic pc,
                                logic [7:0] pad, logic [7:0] ep, logic [7:0] en, logic ef);
        vec_t v;
        v.clr = c; v.dwe = dwe; v.dd = dd; v.pwe = pwe; v.pd = pd; v.nwe = nwe; v.nd = nd;
        v.mwe = mwe; v.md = md; v.pc = pc; v.pad = pad; v.e_port = ep; v.e_pin = en; v.e_pcif = ef;
        return v;
    endfunction

    vec_t vecs [$];

    initial begin
        idle_inputs();
        pad_in = 8'h00;
        // clr dwe dd pwe pd nwe nd mwe md pc pad | port pin pcif  (expectations for the any-edge build)
        vecs.push_back(mk(1,0,8'h00,0,8'h00,0,8'h00,0,8'h00,0,8'hFF, 8'h00,8'h00,0));
        vecs.push_back(mk(0,0,8'h00,0,8'h00,0,8'h00,0,8'h00,0,8'hFF, 8'h00,8'h00,0));
        vecs.push_back(mk(0,0,8'h00,0,8'h00,0,8'h00,0,8'h00,0,8'hFF, 8'h00,8'hFF,0));
        vecs.push_back(mk(0,0,8'h00,0,8'h00,0,8'h00,0,8'h00,0,8'hFF, 8'h00,8'hFF,0));
        vecs.push_back(mk(0,1,8'hFF,1,8'h0F,0,8'h00,0,8'h00,0,8'hFF, 8'h0F,8'hFF,0));
        vecs.push_back(mk(0,0,8'h00,0,8'h00,1,8'hFF,0,8'h00,0,8'hFF, 8'hF0,8'hFF,0));
        vecs.push_back(mk(0,0,8'h00,1,8'h55,1,8'hFF,0,8'h00,0,8'hFF, 8'h55,8'hFF,0));
        vecs.push_back(mk(0,0,8'h00,0,8'h00,0,8'h00,1,8'h01,0,8'hFE, 8'h55,8'hFF,0));
        vecs.push_back(mk(0,0,8'h00,0,8'h00,0,8'h00,0,8'h00,0,8'hFE, 8'h55,8'hFE,0));
        vecs.push_back(mk(0,0,8'h00,0,8'h00,0,8'h00,0,8'h00,0,8'hFE, 8'h55,8'hFE,1));
        vecs.push_back(mk(0,0,8'h00,0,8'h00,0,8'h00,0,8'h00,1,8'hFE, 8'h55,8'hFE,0));
        vecs.push_back(mk(0,0,8'h00,0,8'h00,0,8'h00,0,8'h00,0,8'hFC, 8'h55,8'hFE,0));
        vecs.push_back(mk(0,0,8'h00,0,8'h00,0,8'h00,0,8'h00,0,8'hFC, 8'h55,8'hFC,0));
        vecs.push_back(mk(0,0,8'h00,0,8'h00,0,8'h00,0,8'h00,0,8'hFC, 8'h55,8'hFC,0));
        vecs.push_back(mk(0,0,8'h00,0,8'h00,0,8'h00,0,8'h00,0,8'hFD, 8'h55,8'hFC,0));
        vecs.push_back(mk(0,0,8'h00,0,8'h00,0,8'h00,0,8'h00,0,8'hFD, 8'h55,8'hFD,0));
        vecs.push_back(mk(0,0,8'h00,0,8'h00,0,8'h00,0,8'h00,0,8'hFD, 8'h55,8'hFD,1));
        vecs.push_back(mk(0,0,8'h00,0,8'h00,0,8'h00,0,8'h00,0,8'hFC, 8'h55,8'hFD,1));
        vecs.push_back(mk(0,0,8'h00,0,8'h00,0,8'h00,0,8'h00,0,8'hFC, 8'h55,8'hFC,1));
        vecs.push_back(mk(0,0,8'h00,0,8'h00,0,8'h00,0,8'h00,1,8'hFC, 8'h55,8'hFC,1));
        vecs.push_back(mk(0,0,8'h00,0,8'h00,0,8'h00,0,8'h00,1,8'hFC, 8'h55,8'hFC,0));
        vecs.push_back(mk(0,0,8'h00,0,8'h00,0,8'h00,0,8'h00,0,8'hFD, 8'h55,8'hFC,0));
        vecs.push_back(mk(0,0,8'h00,0,8'h00,0,8'h00,0,8'h00,0,8'hFD, 8'h55,8'hFD,0));
        vecs.push_back(mk(0,0,8'h00,0,8'h00,0,8'h00,1,8'h00,0,8'hFD, 8'h55,8'hFD,1));
        vecs.push_back(mk(0,0,8'h00,0,8'h00,0,8'h00,0,8'h00,1,8'hFC, 8'h55,8'hFD,0));
        vecs.push_back(mk(0,0,8'h00,0,8'h00,0,8'h00,0,8'h00,0,8'hFC, 8'h55,8'hFC,0));
        vecs.push_back(mk(0,0,8'h00,0,8'h00,0,8'h00,0,8'h00,0,8'hFC, 8'h55,8'hFC,0));

        @(negedge clk);
        foreach (vecs[n]) begin
            clr = vecs[n].clr; ddr_we = vecs[n].dwe; ddr_wdata = vecs[n].dd;
            port_we = vecs[n].pwe; port_wdata = vecs[n].pd; pin_we = vecs[n].nwe; pin_wdata = vecs[n].nd;
            pcmsk_we = vecs[n].mwe; pcmsk_wdata = vecs[n].md; pcif_clr = vecs[n].pc; pad_in = vecs[n].pad;
            step();
            check($sformatf("vec%0d port", n), port_o[0], vecs[n].e_port);
            check($sformatf("vec%0d pin", n),  pin_o[0],  vecs[n].e_pin);
            check($sformatf("vec%0d pcif", n), {7'd0, pcif_o[0]}, {7'd0, vecs[n].e_pcif});
        end

        // Reset mid-operation drops a pending flag and the arm counter.
        idle_inputs(); port_we = 1; port_wdata = 8'hAA; pcmsk_we = 1; pcmsk_wdata = 8'hFF; pad_in = 8'h00;
        step();
        step_pad(8'h00); step_pad(8'h00); step_pad(8'h00);
        check("t6 pcif set", {7'd0, pcif_o[0]}, 8'h01);
        check("t6 port AA", port_o[0], 8'hAA);
        idle_inputs(); clr = 1; step();
        check("t6 pcif cleared", {7'd0, pcif_o[0]}, 8'h00);
        check("t6 port reset", port_o[0], 8'h00);
        check("t6 pcif1 cleared", {7'd0, pcif_o[1]}, 8'h00);
        idle_inputs(); pcmsk_we = 1; pcmsk_wdata = 8'hFF; pad_in = 8'hFF; step();
        step_pad(8'hFF);
        step_pad(8'h00);
        check("t6 unarmed", {7'd0, pcif_o[0]}, 8'h00);
        step_pad(8'h00);
        step_pad(8'h00);
        check("t6 rearmed", {7'd0, pcif_o[0]}, 8'h01);

        // Falling-only build ignores rises; pull-up follows PORT on input pins.
        for (int k = 0; k < 4; k++) step_pad(8'h00);
        idle_inputs(); ddr_we = 1; ddr_wdata = 8'h00; port_we = 1; port_wdata = 8'h80; pcif_clr = 1; pad_in = 8'h00;
        step();
        check("t5 pad_pu", pu_o[0], 8'h80);
        check("t5 pad_do", do_o[0], 8'h00);
        check("t5 pcif1 clr", {7'd0, pcif_o[1]}, 8'h00);
        for (int k = 0; k < 5; k++) step_pad(8'h01);
        check("t5 rise no flag", {7'd0, pcif_o[1]}, 8'h00);
        check("t5 rise any-edge flag", {7'd0, pcif_o[0]}, 8'h01);
        for (int k = 0; k < 5; k++) step_pad(8'h00);
        check("t5 fall flag", {7'd0, pcif_o[1]}, 8'h01);

        // Randomised traffic against the model.
        for (int c = 0; c < 600; c++) begin
            clr         = ($urandom_range(0, 59) == 0);
            ddr_we      = ($urandom_range(0, 3) == 0);
            ddr_wdata   = 8'($urandom);
            port_we     = ($urandom_range(0, 3) == 0);
            port_wdata  = 8'($urandom);
            pin_we      = ($urandom_range(0, 3) == 0);
            pin_wdata   = 8'($urandom);
            pcmsk_we    = ($urandom_range(0, 7) == 0);
            pcmsk_wdata = 8'($urandom);
            pcif_clr    = ($urandom_range(0, 5) == 0);
            pad_in      = pad_in ^ 8'($urandom & $urandom & $urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
